// File: rtl/gse_serial_tx.sv
// Ground-checkout serial transmitter: CSTN/TER pulses, HALTV level, framed DIN words.
// Optional: define GSE_TX_PARITY_EN to append an odd-parity bit to each word frame.
module gse_serial_tx #(
  parameter int WORD_BITS = 26,
  parameter int CST_TICKS = 4,
  parameter int TER_TICKS = 1,
  parameter int GAP_TICKS = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 BIT_TICK,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  input  logic [1:0]           CMD_OP,
  input  logic [WORD_BITS-1:0] CMD_DATA,
  output logic                 DIN,
  output logic                 DATAV,
  output logic                 CSTN,
  output logic                 HALTV,
  output logic                 TER,
  output logic                 BUSY,
  output logic                 DONE
);

`ifdef GSE_TX_PARITY_EN
  localparam int FRAME_BITS = WORD_BITS + 1;
`else
  localparam int FRAME_BITS = WORD_BITS;
`endif

  localparam int M1 = (WORD_BITS + 1 > CST_TICKS) ? WORD_BITS + 1 : CST_TICKS;
  localparam int M2 = (TER_TICKS > GAP_TICKS) ? TER_TICKS : GAP_TICKS;
  localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CST_LAST   = CW'(CST_TICKS);
  localparam logic [CW-1:0] TER_LAST   = CW'(TER_TICKS);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_TICKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT,
    S_PULSE,
    S_GAP
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  logic [FRAME_BITS-1:0] frame;
  logic [CW-1:0] pulse_last;
  logic [1:0] op_q, op_d;
  logic din_q, din_d;
  logic datav_q, datav_d;
  logic cstn_q, cstn_d;
  logic ter_q, ter_d;
  logic haltv_q, haltv_d;
  logic done_q, done_d;

`ifdef GSE_TX_PARITY_EN
  // parity bit chosen so the frame carries an odd number of ones
  assign frame = {CMD_DATA, ~^CMD_DATA};
`else
  assign frame = CMD_DATA;
`endif

  assign pulse_last = (op_q == 2'd2) ? TER_LAST : CST_LAST;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    op_d    = op_q;
    din_d   = din_q;
    datav_d = datav_q;
    cstn_d  = cstn_q;
    ter_d   = ter_q;
    haltv_d = haltv_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (CMD_VALID) begin
          op_d = CMD_OP;
          if (CMD_OP == 2'd3) begin
            haltv_d = CMD_DATA[0];
            done_d  = 1'b1;
          end else begin
            sh_d    = frame;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (BIT_TICK) begin
          cnt_d = CW'(1);
          if (op_q == 2'd0) begin
            state_d = S_SHIFT;
            datav_d = 1'b1;
            din_d   = sh_q[FRAME_BITS-1];
            sh_d    = sh_q << 1;
          end else begin
            state_d = S_PULSE;
            cstn_d  = (op_q != 2'd1);
            ter_d   = (op_q == 2'd2);
          end
        end
      end
      S_SHIFT: begin
        if (BIT_TICK) begin
          if (cnt_q == FRAME_LAST) begin
            datav_d = 1'b0;
            din_d   = 1'b0;
            cnt_d   = '0;
            state_d = S_GAP;
          end else begin
            din_d = sh_q[FRAME_BITS-1];
            sh_d  = sh_q << 1;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_PULSE: begin
        if (BIT_TICK) begin
          if (cnt_q == pulse_last) begin
            cstn_d  = 1'b1;
            ter_d   = 1'b0;
            cnt_d   = '0;
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (BIT_TICK) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      op_q    <= 2'd0;
      din_q   <= 1'b0;
      datav_q <= 1'b0;
      cstn_q  <= 1'b1;
      ter_q   <= 1'b0;
      haltv_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      op_q    <= op_d;
      din_q   <= din_d;
      datav_q <= datav_d;
      cstn_q  <= cstn_d;
      ter_q   <= ter_d;
      haltv_q <= haltv_d;
      done_q  <= done_d;
    end
  end

  assign CMD_READY = (state_q == S_IDLE);
  assign BUSY      = (state_q != S_IDLE);
  assign DIN       = din_q;
  assign DATAV     = datav_q;
  assign CSTN      = cstn_q;
  assign TER       = ter_q;
  assign HALTV     = haltv_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_gse_serial_tx.sv
// Directed bench for gse_serial_tx: vector table plus reset and back-pressure sequences.
// Follows GSE_TX_PARITY_EN to pick the expected frame length.
`timescale 1ns/1ps
module tb_gse_serial_tx;

  localparam int WB = 26;
`ifdef GSE_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = WB + PAR;

  logic CLK = 1'b0;
  logic RST;
  logic BIT_TICK;
  logic CMD_VALID;
  logic CMD_READY;
  logic [1:0] CMD_OP;
  logic [WB-1:0] CMD_DATA;
  logic DIN, DATAV, CSTN, HALTV, TER, BUSY, DONE;

  gse_serial_tx dut (
    .CLK(CLK),
    .RST(RST),
    .BIT_TICK(BIT_TICK),
    .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP),
    .CMD_DATA(CMD_DATA),
    .DIN(DIN),
    .DATAV(DATAV),
    .CSTN(CSTN),
    .HALTV(HALTV),
    .TER(TER),
    .BUSY(BUSY),
    .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]    op;
    logic [WB-1:0] data;
    int            per;
    bit            coinc;
    logic          par;
    int            exp_dv;
    int            exp_ticks;
    int            exp_cst;
    int            exp_ter;
    logic          exp_halt;
  } vec_t;

  vec_t vecs[10];

  int n_chk = 0;
  int n_fail = 0;
  int per = 8;
  int phase = 0;
  bit tick_en = 1'b1;
  bit acc;
  int ticks_seen, dv_ticks, cst_ticks, cst_cyc, ter_ticks, done_cnt;
  int overlap = 0;
  logic [31:0] din_log;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_logs();
    ticks_seen = 0;
    dv_ticks   = 0;
    cst_ticks  = 0;
    cst_cyc    = 0;
    ter_ticks  = 0;
    done_cnt   = 0;
    din_log    = '0;
  endtask

  task automatic cyc();
    logic rdy;
    BIT_TICK = tick_en && (phase == per - 1);
    phase = (phase + 1 >= per) ? 0 : phase + 1;
    rdy = CMD_READY;
    acc = CMD_VALID && rdy && !RST;
    @(posedge CLK);
    #1;
    if (BIT_TICK) begin
      ticks_seen++;
      if (DATAV) begin
        dv_ticks++;
        din_log = {din_log[30:0], DIN};
      end
      if (!CSTN) cst_ticks++;
      if (TER) ter_ticks++;
    end
    if (!CSTN) cst_cyc++;
    if (DONE) done_cnt++;
    if (int'(DATAV) + int'(!CSTN) + int'(TER) > 1) overlap++;
  endtask

  task automatic issue(input logic [1:0] op, input logic [WB-1:0] d);
    int k;
    k = 0;
    CMD_OP = op;
    CMD_DATA = d;
    CMD_VALID = 1'b1;
    acc = 1'b0;
    while (!acc && k < 3000) begin
      cyc();
      k++;
    end
    CMD_VALID = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    ticks_seen = 0;
  endtask

  task automatic wait_done(output int td);
    int k;
    k = 0;
    td = ticks_seen;
    while (done_cnt == 0 && k < 3000) begin
      cyc();
      k++;
      td = ticks_seen;
    end
    if (done_cnt == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int td;
    int k;
    logic [31:0] mask;
    logic [31:0] exp_din;

    vecs[0] = '{2'd0, 26'h2AAAAAA, 8, 1'b0, 1'b0, 26, 29, 0, 0, 1'b0};
    vecs[1] = '{2'd1, 26'h0000000, 8, 1'b0, 1'b0, 0, 7, 4, 0, 1'b0};
    vecs[2] = '{2'd2, 26'h0000000, 4, 1'b0, 1'b0, 0, 4, 0, 1, 1'b0};
    vecs[3] = '{2'd3, 26'h0000001, 8, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1};
    vecs[4] = '{2'd0, 26'h0000001, 5, 1'b0, 1'b0, 26, 29, 0, 0, 1'b1};
    vecs[5] = '{2'd3, 26'h0000000, 8, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0};
    vecs[6] = '{2'd0, 26'h3FFFFFF, 3, 1'b1, 1'b1, 26, 29, 0, 0, 1'b0};
    vecs[7] = '{2'd1, 26'h0000000, 2, 1'b1, 1'b0, 0, 7, 4, 0, 1'b0};
    vecs[8] = '{2'd0, 26'h1234567, 2, 1'b0, 1'b1, 26, 29, 0, 0, 1'b0};
    vecs[9] = '{2'd2, 26'h0000000, 3, 1'b1, 1'b0, 0, 4, 0, 1, 1'b0};

    mask = (32'h1 << NB) - 32'h1;
    RST = 1'b1;
    BIT_TICK = 1'b0;
    CMD_VALID = 1'b0;
    CMD_OP = 2'd0;
    CMD_DATA = '0;
    clear_logs();
    repeat (3) cyc();
    RST = 1'b0;
    cyc();
    chk("reset_outputs", {24'd0, DIN, DATAV, CSTN, HALTV, TER, BUSY, DONE, CMD_READY},
        32'b0010_0001);

    // abort a word mid-shift with HALTV set
    clear_logs();
    issue(2'd3, 26'h1);
    wait_done(td);
    chk("pre_reset_halt", {31'd0, HALTV}, 32'd1);
    clear_logs();
    issue(2'd0, 26'h2AAAAAA);
    k = 0;
    while (dv_ticks < 5 && k < 1000) begin
      cyc();
      k++;
    end
    chk("midshift_busy", {30'd0, BUSY, DATAV}, 32'b11);
    RST = 1'b1;
    cyc();
    chk("midshift_reset", {24'd0, DIN, DATAV, CSTN, HALTV, TER, BUSY, DONE, CMD_READY},
        32'b0010_0001);
    cyc();
    cyc();
    RST = 1'b0;
    done_cnt = 0;
    repeat (40) cyc();
    chk("post_reset_idle", {28'd0, done_cnt[1:0], CMD_READY, BUSY}, 32'b0010);

    for (int i = 0; i < 10; i++) begin
      per = vecs[i].per;
      phase = vecs[i].coinc ? per - 1 : 0;
      clear_logs();
      issue(vecs[i].op, vecs[i].data);
      if (vecs[i].coinc) chk($sformatf("v%0d_coinc_nobit", i), {31'd0, DATAV}, 32'd0);
      wait_done(td);
      chk($sformatf("v%0d_ticks", i), td,
          vecs[i].exp_ticks + ((vecs[i].op == 2'd0) ? PAR : 0));
      chk($sformatf("v%0d_dv", i), dv_ticks,
          vecs[i].exp_dv + ((vecs[i].op == 2'd0) ? PAR : 0));
      chk($sformatf("v%0d_cst", i), cst_ticks, vecs[i].exp_cst);
      chk($sformatf("v%0d_cst_cyc", i), cst_cyc, vecs[i].exp_cst * per);
      chk($sformatf("v%0d_ter", i), ter_ticks, vecs[i].exp_ter);
      if (vecs[i].op == 2'd0) begin
        exp_din = (PAR != 0) ? ((32'(vecs[i].data) << 1) | 32'(vecs[i].par))
                             : 32'(vecs[i].data);
        chk($sformatf("v%0d_din", i), din_log & mask, exp_din);
      end
      repeat (3) cyc();
      chk($sformatf("v%0d_done_once", i), done_cnt, 1);
      chk($sformatf("v%0d_halt", i), {31'd0, HALTV}, {31'd0, vecs[i].exp_halt});
      chk($sformatf("v%0d_idle", i), {30'd0, CMD_READY, BUSY}, 32'b10);
    end

    // TER held on CMD_VALID while a word is in flight
    per = 4;
    phase = 0;
    clear_logs();
    issue(2'd0, 26'h0F0F0F0);
    CMD_OP = 2'd2;
    CMD_DATA = '0;
    CMD_VALID = 1'b1;
    acc = 1'b0;
    k = 0;
    while (!acc && k < 3000) begin
      cyc();
      k++;
    end
    CMD_VALID = 1'b0;
    chk("bp_accepted", {31'd0, acc}, 32'd1);
    chk("bp_word_done_first", done_cnt, 1);
    chk("bp_word_bits", dv_ticks, NB);
    chk("bp_no_ter_yet", ter_ticks, 0);
    ticks_seen = 0;
    ter_ticks = 0;
    done_cnt = 0;
    wait_done(td);
    chk("bp_ter_ticks", ter_ticks, 1);
    chk("bp_ter_total", td, 4);

    chk("exclusive_outputs", overlap, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
